// File: rtl/wb_merge.sv
// ============================================================================
// wb_merge : register-file writeback merger for the commit stage and the MDU
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_merge #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_valid,
  output logic                     pipe_ready,
  input  logic [4:0]               pipe_wa,
  input  logic [63:0]              pipe_wd,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_wa,
  input  logic [63:0]              mdu_wd,
  output logic                     wvalid,
  output logic [4:0]               wa,
  output logic [63:0]              wd,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
  localparam logic [SW-1:0] C_SLIM  = SW'(STARVE_LIMIT);

  logic [68:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          wvalid_q, wvalid_d;
  logic [4:0]    wa_q, wa_d;
  logic [63:0]   wd_q, wd_d;

  logic          force_drain;
  logic          fifo_empty;
  logic          pipe_wr;
  logic          push;
  logic          pop;
  logic [68:0]   head;

  assign fifo_empty  = (count_q == '0);
  assign force_drain = !fifo_empty && (starve_q == C_SLIM);
  assign pipe_ready  = !force_drain;
  assign mdu_ready   = (count_q < C_FULL);

  // x0 writes complete their handshake but never reach the FIFO or the port
  assign pipe_wr = pipe_valid && pipe_ready && (pipe_wa != 5'd0);
  assign push    = mdu_valid && mdu_ready && (mdu_wa != 5'd0);
  assign pop     = force_drain || (!pipe_wr && !fifo_empty);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wvalid_d = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    if (pop) begin
      wvalid_d = 1'b1;
      wa_d     = head[68:64];
      wd_d     = head[63:0];
    end else if (pipe_wr) begin
      wvalid_d = 1'b1;
      wa_d     = pipe_wa;
      wd_d     = pipe_wd;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (pipe_wr && (starve_q != C_SLIM)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Storage carries no reset; the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {mdu_wa, mdu_wd};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wvalid_q <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wvalid_q <= wvalid_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  assign wvalid     = wvalid_q;
  assign wa         = wa_q;
  assign wd         = wd_q;
  assign fifo_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_merge.sv
// ============================================================================
// tb_wb_merge : directed scenarios plus a randomized run against a queue model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_wb_merge;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_ready;
  logic [4:0]  pipe_wa;
  logic [63:0] pipe_wd;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_wa;
  logic [63:0] mdu_wd;
  logic        wvalid;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic [2:0]  fifo_count;

  int vectors    = 0;
  int miscompares = 0;

  wb_merge #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_valid (pipe_valid),
    .pipe_ready (pipe_ready),
    .pipe_wa    (pipe_wa),
    .pipe_wd    (pipe_wd),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_wa     (mdu_wa),
    .mdu_wd     (mdu_wd),
    .wvalid     (wvalid),
    .wa         (wa),
    .wd         (wd),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid = 1'b0; pipe_wa = '0; pipe_wd = '0;
    mdu_valid  = 1'b0; mdu_wa  = '0; mdu_wd  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (wvalid !== 1'b0) begin miscompares++; $display("FAIL reset_wvalid_low got=%b exp=0", wvalid); end
    reset = 1'b1;
    #1;
    vectors++;
    if ({wvalid, fifo_count, pipe_ready, mdu_ready} !== {1'b0, 3'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state got wv=%b cnt=%0d pr=%b mr=%b exp wv=0 cnt=0 pr=1 mr=1",
               wvalid, fifo_count, pipe_ready, mdu_ready);
    end
    vectors++;
    if ({wa, wd} !== 69'd0) begin miscompares++; $display("FAIL reset_wa_wd got wa=%0d wd=%h exp 0/0", wa, wd); end
  endtask

  task automatic test_pipe_single();
    pipe_valid = 1'b1; pipe_wa = 5'd5; pipe_wd = 64'h1234;
    #1;
    vectors++;
    if (pipe_ready !== 1'b1) begin miscompares++; $display("FAIL pipe_ready got=%b exp=1", pipe_ready); end
    cyc();
    pipe_valid = 1'b0;
    vectors++;
    if ({wvalid, wa, wd} !== {1'b1, 5'd5, 64'h1234}) begin
      miscompares++; $display("FAIL pipe_write got wv=%b wa=%0d wd=%h exp 1/5/1234", wvalid, wa, wd);
    end
    cyc();
    vectors++;
    if ({wvalid, wa, wd} !== {1'b0, 5'd5, 64'h1234}) begin
      miscompares++; $display("FAIL pipe_idle_hold got wv=%b wa=%0d wd=%h exp 0/5/1234", wvalid, wa, wd);
    end
  endtask

  task automatic test_mdu_back_to_back();
    mdu_valid = 1'b1; mdu_wa = 5'd7; mdu_wd = 64'hA;
    cyc();
    mdu_wa = 5'd8; mdu_wd = 64'hB;
    vectors++;
    if ({wvalid, fifo_count} !== {1'b0, 3'd1}) begin
      miscompares++; $display("FAIL mdu_t1 got wv=%b cnt=%0d exp wv=0 cnt=1", wvalid, fifo_count);
    end
    cyc();
    mdu_valid = 1'b0;
    vectors++;
    if ({wvalid, wa, wd, fifo_count} !== {1'b1, 5'd7, 64'hA, 3'd1}) begin
      miscompares++; $display("FAIL mdu_t2 got wv=%b wa=%0d wd=%h cnt=%0d exp 1/7/a/1", wvalid, wa, wd, fifo_count);
    end
    cyc();
    vectors++;
    if ({wvalid, wa, wd, fifo_count} !== {1'b1, 5'd8, 64'hB, 3'd0}) begin
      miscompares++; $display("FAIL mdu_t3 got wv=%b wa=%0d wd=%h cnt=%0d exp 1/8/b/0", wvalid, wa, wd, fifo_count);
    end
    cyc();
    vectors++;
    if (wvalid !== 1'b0) begin miscompares++; $display("FAIL mdu_t4 got wv=%b exp=0", wvalid); end
  endtask

  task automatic test_starvation();
    pipe_valid = 1'b1; pipe_wa = 5'd3; pipe_wd = 64'h33;
    mdu_valid  = 1'b1; mdu_wa  = 5'd9; mdu_wd  = 64'hC;
    cyc();
    mdu_valid = 1'b0;
    vectors++;
    if ({wvalid, wa, fifo_count} !== {1'b1, 5'd3, 3'd1}) begin
      miscompares++; $display("FAIL starve_fill got wv=%b wa=%0d cnt=%0d exp 1/3/1", wvalid, wa, fifo_count);
    end
    for (int k = 1; k <= 3; k++) begin
      vectors++;
      if (pipe_ready !== 1'b1) begin miscompares++; $display("FAIL starve_pr_%0d got=%b exp=1", k, pipe_ready); end
      cyc();
    end
    vectors++;
    if ({pipe_ready, wvalid, wa} !== {1'b0, 1'b1, 5'd3}) begin
      miscompares++; $display("FAIL starve_force got pr=%b wv=%b wa=%0d exp pr=0 wv=1 wa=3", pipe_ready, wvalid, wa);
    end
    cyc();
    vectors++;
    if ({wvalid, wa, wd, fifo_count, pipe_ready} !== {1'b1, 5'd9, 64'hC, 3'd0, 1'b1}) begin
      miscompares++; $display("FAIL starve_drain got wv=%b wa=%0d wd=%h cnt=%0d pr=%b exp 1/9/c/0/1",
                              wvalid, wa, wd, fifo_count, pipe_ready);
    end
    cyc();
    pipe_valid = 1'b0;
    vectors++;
    if ({wvalid, wa, wd} !== {1'b1, 5'd3, 64'h33}) begin
      miscompares++; $display("FAIL starve_resume got wv=%b wa=%0d wd=%h exp 1/3/33", wvalid, wa, wd);
    end
    cyc();
  endtask

  task automatic test_full_x0();
    pipe_valid = 1'b1; pipe_wa = 5'd4; pipe_wd = 64'h44;
    mdu_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mdu_wa = 5'(10 + k); mdu_wd = 64'(16'hD0 + k);
      cyc();
    end
    mdu_wa = 5'd0; mdu_wd = 64'hDEAD;
    vectors++;
    if ({mdu_ready, fifo_count, pipe_ready} !== {1'b0, 3'd4, 1'b0}) begin
      miscompares++; $display("FAIL full got mr=%b cnt=%0d pr=%b exp mr=0 cnt=4 pr=0", mdu_ready, fifo_count, pipe_ready);
    end
    cyc();
    vectors++;
    if ({wvalid, wa, wd, mdu_ready, fifo_count} !== {1'b1, 5'd10, 64'hD0, 1'b1, 3'd3}) begin
      miscompares++; $display("FAIL full_drain got wv=%b wa=%0d wd=%h mr=%b cnt=%0d exp 1/10/d0/1/3",
                              wvalid, wa, wd, mdu_ready, fifo_count);
    end
    cyc();
    mdu_valid = 1'b0;
    pipe_wa = 5'd0;
    vectors++;
    if ({wvalid, wa, fifo_count} !== {1'b1, 5'd4, 3'd3}) begin
      miscompares++; $display("FAIL mdu_x0 got wv=%b wa=%0d cnt=%0d exp 1/4/3", wvalid, wa, fifo_count);
    end
    cyc();
    vectors++;
    if ({wvalid, wa, wd, fifo_count} !== {1'b1, 5'd11, 64'hD1, 3'd2}) begin
      miscompares++; $display("FAIL pipe_x0 got wv=%b wa=%0d wd=%h cnt=%0d exp 1/11/d1/2", wvalid, wa, wd, fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    pipe_valid = 1'b1; pipe_wa = 5'd4; pipe_wd = 64'h44;
    mdu_valid  = 1'b1; mdu_wa  = 5'd14; mdu_wd = 64'hD4;
    cyc();
    idle_inputs();
    vectors++;
    if ({fifo_count, wvalid} !== {3'd3, 1'b1}) begin
      miscompares++; $display("FAIL pre_reset got cnt=%0d wv=%b exp cnt=3 wv=1", fifo_count, wvalid);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({wvalid, wa, wd, fifo_count} !== {1'b0, 5'd0, 64'd0, 3'd0}) begin
      miscompares++; $display("FAIL async_reset got wv=%b wa=%0d wd=%h cnt=%0d exp all 0", wvalid, wa, wd, fifo_count);
    end
    cyc(); cyc();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      vectors++;
      if ({wvalid, fifo_count} !== {1'b0, 3'd0}) begin
        miscompares++; $display("FAIL stale_write_%0d got wv=%b cnt=%0d exp wv=0 cnt=0", k, wvalid, fifo_count);
      end
    end
  endtask

  // Reference: a queue of pending MDU results and a count of denied cycles
  task automatic test_random(input int cycles);
    logic [68:0] q[$];
    int          starve = 0;
    logic        exp_wv = 1'b0;
    logic [4:0]  exp_wa = '0;
    logic [63:0] exp_wd = '0;
    logic        p_hold = 1'b0, m_hold = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      logic exp_pr, exp_mr, p_x, m_x, p_w, popped;
      int   pre_size;
      int   p_prob;
      p_prob = ((c / 100) % 2 == 0) ? 90 : 40;
      if (!p_hold) begin
        pipe_valid = ($urandom_range(99) < p_prob);
        pipe_wa    = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
        pipe_wd    = {$urandom, $urandom};
      end
      if (!m_hold) begin
        mdu_valid = ($urandom_range(99) < 55);
        mdu_wa    = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
        mdu_wd    = {$urandom, $urandom};
      end
      exp_pr = !(q.size() != 0 && starve == 3);
      exp_mr = (q.size() < 4);
      #1;
      vectors++;
      if ({pipe_ready, mdu_ready} !== {exp_pr, exp_mr}) begin
        miscompares++; $display("FAIL rand_ready c=%0d got pr=%b mr=%b exp pr=%b mr=%b",
                                c, pipe_ready, mdu_ready, exp_pr, exp_mr);
      end
      p_x = pipe_valid && exp_pr;
      m_x = mdu_valid && exp_mr;
      p_w = p_x && (pipe_wa != 5'd0);
      pre_size = q.size();
      popped = 1'b0;
      if (!exp_pr || (!p_w && pre_size > 0)) begin
        exp_wv = 1'b1;
        {exp_wa, exp_wd} = q.pop_front();
        popped = 1'b1;
      end else if (p_w) begin
        exp_wv = 1'b1; exp_wa = pipe_wa; exp_wd = pipe_wd;
      end else begin
        exp_wv = 1'b0;
      end
      if (popped || pre_size == 0) starve = 0;
      else if (p_w && starve < 3) starve++;
      if (m_x && mdu_wa != 5'd0) q.push_back({mdu_wa, mdu_wd});
      p_hold = pipe_valid && !p_x;
      m_hold = mdu_valid && !m_x;
      cyc();
      vectors++;
      if ({wvalid, wa, wd, fifo_count} !== {exp_wv, exp_wa, exp_wd, 3'(q.size())}) begin
        miscompares++; $display("FAIL rand_out c=%0d got wv=%b wa=%0d wd=%h cnt=%0d exp wv=%b wa=%0d wd=%h cnt=%0d",
                                c, wvalid, wa, wd, fifo_count, exp_wv, exp_wa, exp_wd, q.size());
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_pipe_single();
    test_mdu_back_to_back();
    test_starvation();
    test_full_x0();
    test_reset_mid();
    test_random(800);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_merge.md
Name: wb_merge

Overview:
- Writeback merger that owns the register file's single write port (wvalid/wa/wd) and arbitrates between two producers.
  - The in-order pipeline commit stage produces one result per cycle at most.
  - The multi-cycle MDU (mul/div) produces results out of band.
- MDU results are buffered in a small FIFO.
- Pipeline commits win by default; a starvation guard forces MDU drains.

Parameters:
- DEPTH, 4: MDU result FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 3: consecutive cycles a non-empty FIFO may be denied before a forced drain.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- pipe_valid  input  1  commit stage presents a result.
- pipe_ready  output  1  merger accepts the pipe result this cycle.
- pipe_wa  input  5  destination register.
- pipe_wd  input  64  result data.
- mdu_valid  input  1  MDU presents a result.
- mdu_ready  output  1  FIFO can accept this cycle.
- mdu_wa  input  5  destination register.
- mdu_wd  input  64  result data.
- wvalid  output  1  register-file write enable (registered).
- wa  output  5  register-file write address (registered).
- wd  output  64  register-file write data (registered).
- fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy (registered).

Behaviour:
- Reset (reset low, asynchronous):
  - wvalid=0, wa=0, wd=0.
  - FIFO empty, fifo_count=0, starvation counter=0.
  - pipe_ready=1, mdu_ready=1 as soon as reset deasserts.
  - Reset mid-operation discards all buffered results; nothing is written out.
- Handshakes:
  - pipe transfer = pipe_valid && pipe_ready.
  - mdu transfer = mdu_valid && mdu_ready.
  - Producers hold valid, wa and wd stable until the transfer.
- mdu_ready = (fifo_count < DEPTH), from registered state only.
  - No push when full, even if a pop occurs the same cycle.
- pipe_ready = !force, where force = (fifo_count != 0) && (starve_cnt == STARVE_LIMIT).
- Writes to x0 (wa==0) from either source:
  - Complete the handshake.
  - Are discarded: no FIFO push, no output slot used.
- Output selection, one write per cycle, registered with 1-cycle latency:
  - (1) force → pop FIFO head to output; pipe not accepted.
  - (2) else pipe transfer with pipe_wa!=0 → pipe result to output.
  - (3) else FIFO non-empty → pop head to output.
  - (4) else wvalid=0; wa and wd hold their previous values.
- MDU latency: mdu transfer at cycle t → earliest wvalid at t+2.
  - The FIFO is always used; there is no bypass.
- FIFO ordering:
  - Strict FIFO order among MDU results.
  - No ordering is guaranteed between pipe and MDU; the issue-side scoreboard prevents WAW between sources.
- Simultaneous push and pop on the same cycle are both honoured; fifo_count is unchanged.
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- starve_cnt:
  - Increments when FIFO non-empty and option (2) wins.
  - Clears on any FIFO pop, or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Output regs are always written by the selected source.
  - A downstream register file with a combinational read bypass sees the data in the same cycle wvalid is high.

Test Plan:
- Reset low for 3 cycles, release → wvalid=0, fifo_count=0, pipe_ready=1, mdu_ready=1.
- Pipe commit wa=5, wd=0x1234 at cycle t → at t+1: wvalid=1, wa=5, wd=0x1234; at t+2: wvalid=0 (no further input).
- MDU pushes wa=7/0xA and wa=8/0xB back-to-back, pipe idle:
  - wa=7 written at t+2, wa=8 at t+3.
  - fifo_count sequence 1,1,0.
- Starvation:
  - Fill FIFO with wa=9/0xC.
  - Hold pipe_valid=1 with wa=3 continuously.
  - After 3 pipe writes, pipe_ready=0 for one cycle.
  - wa=9 is written on the next cycle.
  - The pipe result is accepted on the following cycle.
- Full and x0:
  - Push 4 MDU results while pipe is busy → mdu_ready=0, fifo_count=4.
  - An MDU result with wa=0 is accepted and not enqueued.
  - A pipe result with wa=0 lets a FIFO entry drain that cycle.
- Reset asserted with fifo_count=3 → outputs clear immediately (asynchronous); after release no stale writes appear.
